// File: rtl/ec_fe_pkg.sv
// rtl/ec_fe_pkg.sv - shared sizes, gene type and FSM states for the chromosome fetch unit
package ec_fe_pkg;

    localparam int GENE_WIDTH = 8;
    localparam int NUM_GENES  = 16;
    localparam int POP_SIZE   = 32;
    localparam int IDX_W      = $clog2(POP_SIZE);
    localparam int GIDX_W     = $clog2(NUM_GENES);
    localparam int ADDR_W     = $clog2(POP_SIZE * NUM_GENES);

    typedef logic [GENE_WIDTH-1:0] gene_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fe_state_e;

endpackage

// File: rtl/ec_counter.sv
// rtl/ec_counter.sv - up counter with synchronous clear (priority) and enable
// Ports: clk_i/rst_n_i clock and async active-low reset, clr_i clear, en_i count enable,
//        cnt_o current count.
module ec_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gene_skid_fifo.sv
// rtl/gene_skid_fifo.sv - 2-entry FIFO that absorbs one cycle of memory read latency
// Ports: clk_i/rst_n_i clock and async active-low reset, flush_i drops all entries,
//        push_i/wdata_i write side, pop_i read side, valid_o non-empty, rdata_o head,
//        occ_o occupancy 0..2.
module gene_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            // Flush wins over a same-cycle push: that data belongs to an aborted fetch.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

    no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !pop_i && !flush_i && occ_q == 2'd2));

endmodule

// File: rtl/chrom_fetch_unit.sv
// rtl/chrom_fetch_unit.sv - reads one chromosome from population SRAM and streams its genes
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/chrom_idx_i fetch request;
//        abort_i flush; busy_o/done_o/err_o status; mem_rd_en_o/mem_addr_o/mem_rdata_i
//        1-cycle-latency SRAM read port; gene_valid_o/gene_ready_i/gene_data_o/gene_idx_o/
//        gene_last_o gene stream.
module chrom_fetch_unit #(
    parameter int  GENE_WIDTH = ec_fe_pkg::GENE_WIDTH,
    parameter int  NUM_GENES  = ec_fe_pkg::NUM_GENES,
    parameter int  POP_SIZE   = ec_fe_pkg::POP_SIZE,
    localparam int IDX_W      = $clog2(POP_SIZE),
    localparam int GIDX_W     = $clog2(NUM_GENES),
    localparam int ADDR_W     = $clog2(POP_SIZE * NUM_GENES)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [IDX_W-1:0]      chrom_idx_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic [GENE_WIDTH-1:0] mem_rdata_i,
    output logic                  gene_valid_o,
    input  logic                  gene_ready_i,
    output logic [GENE_WIDTH-1:0] gene_data_o,
    output logic [GIDX_W-1:0]     gene_idx_o,
    output logic                  gene_last_o
);

    import ec_fe_pkg::*;

    fe_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              inflight_q, inflight_d;
    logic              err_q, err_d;

    logic [GIDX_W:0]   issue_cnt;
    logic [GIDX_W-1:0] accept_cnt;
    logic [1:0]        occ;
    logic              pop;
    logic              idx_ok;
    logic              issue_clr;
    logic              accept_clr;
    logic              fifo_flush;

    assign idx_ok = ({1'b0, chrom_idx_i} < (IDX_W + 1)'(POP_SIZE));
    assign pop    = gene_valid_o && gene_ready_i;

    // A read is allowed only if its data is guaranteed a FIFO slot when it returns:
    // entries held plus the read still in flight, less what leaves this cycle, must be < 2.
    assign mem_rd_en_o = (state_q == FETCH) &&
                         (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    assign mem_addr_o  = base_q + ADDR_W'(issue_cnt);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        inflight_d = mem_rd_en_o;
        err_d      = 1'b0;
        issue_clr  = 1'b0;
        accept_clr = 1'b0;
        fifo_flush = 1'b0;
        if (abort_i) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
            fifo_flush = 1'b1;
            issue_clr  = 1'b1;
            accept_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (idx_ok) begin
                            state_d   = FETCH;
                            base_d    = ADDR_W'(chrom_idx_i) * ADDR_W'(NUM_GENES);
                            issue_clr = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Leave as the final read is issued so no extra read slot is wasted.
                    if (mem_rd_en_o && issue_cnt == (GIDX_W + 1)'(NUM_GENES - 1)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && gene_last_o) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    accept_clr = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    ec_counter #(.W(GIDX_W + 1)) u_issue_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (issue_clr),
        .en_i    (mem_rd_en_o),
        .cnt_o   (issue_cnt)
    );

    ec_counter #(.W(GIDX_W)) u_accept_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (accept_clr),
        .en_i    (pop),
        .cnt_o   (accept_cnt)
    );

    gene_skid_fifo #(.WIDTH(GENE_WIDTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (fifo_flush),
        .push_i  (inflight_q),
        .wdata_i (mem_rdata_i),
        .pop_i   (pop),
        .valid_o (gene_valid_o),
        .rdata_o (gene_data_o),
        .occ_o   (occ)
    );

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign gene_idx_o  = accept_cnt;
    assign gene_last_o = gene_valid_o && (accept_cnt == GIDX_W'(NUM_GENES - 1));

endmodule
